// File: rtl/tape_pkg.sv
// Shared types and constants for the cassette playback path.
package tape_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_GAP,
      ST_LEADER,
      ST_FETCH,
      ST_WAIT_ACK,
      ST_SEND,
      ST_WAIT_DONE,
      ST_PAUSE,
      ST_END
   } tape_state_t;

   localparam logic [7:0] LEADER_BYTE = 8'h55;
   localparam logic [7:0] SYNC_BYTE   = 8'h7F;
   localparam int         HDR_RUN_MIN = 4;

endpackage

// File: rtl/tape_sequencer_if.sv
// Image-buffer read port plus bit-generator handshake seen by the tape sequencer.
interface tape_sequencer_if #(
   parameter int ADDR_W = 24
);
   logic              buf_rd;
   logic [ADDR_W-1:0] buf_addr;
   logic [7:0]        buf_data;
   logic              buf_ack;
   logic              gen_start;
   logic [7:0]        gen_din;
   logic              gen_extend;
   logic              gen_done;

   modport master (
      output buf_rd, buf_addr, gen_start, gen_din, gen_extend,
      input  buf_data, buf_ack, gen_done
   );

   modport slave (
      input  buf_rd, buf_addr, gen_start, gen_din, gen_extend,
      output buf_data, buf_ack, gen_done
   );
endinterface

// File: rtl/tape_hdr_detect.sv
// Flags a sync byte that follows a run of at least HDR_RUN_MIN leader-valued data bytes.
module tape_hdr_detect
   import tape_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clr,
   input  logic       byte_vld,
   input  logic [7:0] byte_in,
   output logic       hdr
);
   localparam int RW = $clog2(HDR_RUN_MIN + 1);

   logic [RW-1:0] run_q;

   assign hdr = (byte_in == SYNC_BYTE) && (run_q >= RW'(HDR_RUN_MIN));

   // Run length saturates at the threshold; longer runs behave identically.
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         run_q <= '0;
      end else if (byte_vld) begin
         if (byte_in != LEADER_BYTE)
            run_q <= '0;
         else if (run_q < RW'(HDR_RUN_MIN))
            run_q <= run_q + 1'b1;
      end
   end
endmodule

// File: rtl/tape_sequencer.sv
// Cassette image playback controller: gap/leader insertion, motor follow, generator handshake.
// Optional block-header re-sync (extra gap + leader before a 0x7F sync byte): TAPE_HDR_DETECT_EN.
module tape_sequencer
   import tape_pkg::*;
#(
   parameter int          LEADER_BYTES = 256,
   parameter logic [23:0] GAP_CYCLES   = 24'd21_333_333,
   parameter int          ADDR_W       = 24
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              play,
   input  logic              rewind,
   input  logic              motor,
   input  logic [ADDR_W-1:0] img_size,
   tape_sequencer_if.master  bus,
   output logic              busy,
   output logic              eof
);
   localparam int LW = $clog2(LEADER_BYTES + 2);

   tape_state_t       state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d, addr_nxt;
   logic [7:0]        din_q, din_d;
   logic              ext_q, ext_d;
   logic              leader_q, leader_d;
   logic              seen_low_q, seen_low_d;
   logic [LW-1:0]     lcnt_q, lcnt_d;
   logic [23:0]       gcnt_q, gcnt_d;
   logic              rd_q, start_q;
   logic              gap_done, resume;

   assign addr_nxt = (addr_q != img_size) ? addr_q + 1'b1 : addr_q;
   assign gap_done = ({1'b0, gcnt_q} + 25'd1) >= {1'b0, GAP_CYCLES};
   assign resume   = motor & play;

`ifdef TAPE_HDR_DETECT_EN
   logic hdr_pend_q, hdr_pend_d, hdr_hit;

   tape_hdr_detect u_hdr (
      .clk      (clk),
      .reset    (reset),
      .clr      ((state_q == ST_GAP) && gap_done),
      .byte_vld ((state_q == ST_WAIT_ACK) && bus.buf_ack),
      .byte_in  (bus.buf_data),
      .hdr      (hdr_hit)
   );
`endif

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      din_d      = din_q;
      ext_d      = ext_q;
      leader_d   = leader_q;
      seen_low_d = seen_low_q;
      lcnt_d     = lcnt_q;
      gcnt_d     = gcnt_q;
`ifdef TAPE_HDR_DETECT_EN
      hdr_pend_d = hdr_pend_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (rewind) begin
               addr_d = '0;
            end else if (resume && (addr_q < img_size)) begin
               state_d = ST_GAP;
               gcnt_d  = '0;
            end
         end
         ST_GAP: begin
            if (gap_done) begin
               state_d = ST_LEADER;
               lcnt_d  = '0;
            end else begin
               gcnt_d = gcnt_q + 1'b1;
            end
         end
         ST_LEADER: begin
            if (lcnt_q == LW'(LEADER_BYTES)) begin
`ifdef TAPE_HDR_DETECT_EN
               // A held-back sync byte goes out straight after its inserted leader.
               if (hdr_pend_q) begin
                  din_d      = SYNC_BYTE;
                  ext_d      = 1'b1;
                  leader_d   = 1'b0;
                  hdr_pend_d = 1'b0;
                  state_d    = ST_SEND;
               end else begin
                  state_d = ST_FETCH;
               end
`else
               state_d = ST_FETCH;
`endif
            end else begin
               din_d    = LEADER_BYTE;
               ext_d    = 1'b0;
               leader_d = 1'b1;
               state_d  = ST_SEND;
            end
         end
         ST_FETCH: state_d = ST_WAIT_ACK;
         ST_WAIT_ACK: begin
            if (bus.buf_ack) begin
`ifdef TAPE_HDR_DETECT_EN
               if (hdr_hit) begin
                  hdr_pend_d = 1'b1;
                  gcnt_d     = '0;
                  state_d    = ST_GAP;
               end else begin
`else
               begin
`endif
                  din_d    = bus.buf_data;
                  ext_d    = 1'b1;
                  leader_d = 1'b0;
                  state_d  = ST_SEND;
               end
            end
         end
         ST_SEND: begin
            seen_low_d = 1'b0;
            state_d    = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            // A done still high from the previous byte must drop before it counts.
            if (!seen_low_q) begin
               if (!bus.gen_done) seen_low_d = 1'b1;
            end else if (bus.gen_done) begin
               if (leader_q) begin
                  lcnt_d  = lcnt_q + 1'b1;
                  state_d = resume ? ST_LEADER : ST_PAUSE;
               end else begin
                  addr_d = addr_nxt;
                  if (addr_nxt == img_size) state_d = ST_END;
                  else if (!resume)         state_d = ST_PAUSE;
                  else                      state_d = ST_FETCH;
               end
            end
         end
         ST_PAUSE: begin
            if (rewind) begin
               addr_d  = '0;
               state_d = ST_IDLE;
`ifdef TAPE_HDR_DETECT_EN
               hdr_pend_d = 1'b0;
`endif
            end else if (resume) begin
               gcnt_d  = '0;
               state_d = ST_GAP;
            end
         end
         ST_END: begin
            if (rewind) begin
               addr_d  = '0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         din_q      <= '0;
         ext_q      <= 1'b0;
         leader_q   <= 1'b0;
         seen_low_q <= 1'b0;
         lcnt_q     <= '0;
         gcnt_q     <= '0;
         rd_q       <= 1'b0;
         start_q    <= 1'b0;
`ifdef TAPE_HDR_DETECT_EN
         hdr_pend_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         din_q      <= din_d;
         ext_q      <= ext_d;
         leader_q   <= leader_d;
         seen_low_q <= seen_low_d;
         lcnt_q     <= lcnt_d;
         gcnt_q     <= gcnt_d;
         rd_q       <= (state_d == ST_FETCH);
         start_q    <= (state_d == ST_SEND);
`ifdef TAPE_HDR_DETECT_EN
         hdr_pend_q <= hdr_pend_d;
`endif
      end
   end

   assign bus.buf_rd     = rd_q;
   assign bus.buf_addr   = addr_q;
   assign bus.gen_start  = start_q;
   assign bus.gen_din    = din_q;
   assign bus.gen_extend = ext_q;
   assign busy           = (state_q != ST_IDLE) && (state_q != ST_END);
   assign eof            = (state_q == ST_END);
endmodule

// File: tb/tb_tape_sequencer.sv
// Bench for tape_sequencer: buffer and 20-cycle generator models, start scoreboard, vector table.
`timescale 1ns/1ps
module tb_tape_sequencer;
   localparam int          LB      = 2;
   localparam logic [23:0] GAP     = 24'd10;
   localparam int          AW      = 24;
   localparam int          GEN_LAT = 20;
   // play/motor set between edges: 1 edge to leave IDLE/PAUSE, GAP cycles, 1 LEADER decision edge
   localparam int          START_LAT = 32'(GAP) + 2;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          play = 1'b0;
   logic          rewind = 1'b0;
   logic          motor = 1'b0;
   logic [AW-1:0] img_size = '0;
   logic          busy, eof;

   tape_sequencer_if #(.ADDR_W(AW)) bus ();

   tape_sequencer #(.LEADER_BYTES(LB), .GAP_CYCLES(GAP), .ADDR_W(AW)) dut (
      .clk(clk), .reset(reset), .play(play), .rewind(rewind), .motor(motor),
      .img_size(img_size), .bus(bus), .busy(busy), .eof(eof)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- buffer model ----------------
   logic [7:0]    mem [16];
   int            ack_lat = 1;
   int            ack_cnt = 0;
   int            rd_count = 0;
   logic [AW-1:0] rd_addr = '0;

   always @(negedge clk) begin
      bus.buf_ack = 1'b0;
      if (ack_cnt > 0) begin
         ack_cnt--;
         if (ack_cnt == 0) begin
            bus.buf_ack  = 1'b1;
            bus.buf_data = mem[rd_addr[3:0]];
         end
      end
      if (bus.buf_rd) begin
         rd_count++;
         ack_cnt = ack_lat;
         rd_addr = bus.buf_addr;
      end
   end

   // ---------------- generator model ----------------
   int gen_cnt = 0;
   int stale_left = 0;
   bit gen_active = 1'b0;
   bit stale_mode = 1'b0;

   always @(negedge clk) begin
      if (bus.gen_start) begin
         gen_cnt    = GEN_LAT;
         gen_active = 1'b1;
         stale_left = stale_mode ? 3 : 0;
      end else if (gen_active) begin
         gen_cnt--;
         if (stale_left > 0) stale_left--;
      end
      bus.gen_done = (stale_left > 0) || (gen_active && gen_cnt == 0);
      if (gen_active && gen_cnt == 0) gen_active = 1'b0;
   end

   // ---------------- scoreboard ----------------
   typedef struct packed {
      logic [7:0] din;
      logic       ext;
   } gen_rec_t;

   gen_rec_t sb_q[$];
   int       start_count = 0;
   int       data_starts = 0;
   logic     prev_start = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_leader();
      for (int i = 0; i < LB; i++) sb_q.push_back('{din: 8'h55, ext: 1'b0});
   endtask

   task automatic push_data(input logic [7:0] b);
      sb_q.push_back('{din: b, ext: 1'b1});
   endtask

   // One clock step; sampled just after the falling edge, scoreboard consumes any start pulse.
   task automatic tick();
      gen_rec_t e;
      @(negedge clk);
      #1;
      if (bus.gen_start) begin
         start_count++;
         if (bus.gen_extend) data_starts++;
         check("start_one_cycle", 32'(prev_start), 0);
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected_start: got din=0x%0h ext=%0b, expected no start", bus.gen_din, bus.gen_extend);
         end else begin
            e = sb_q.pop_front();
            check("gen_din", 32'(bus.gen_din), 32'(e.din));
            check("gen_extend", 32'(bus.gen_extend), 32'(e.ext));
         end
      end
      prev_start = bus.gen_start;
   endtask

   function automatic int counter_of(input int which);
      case (which)
         0:       return start_count;
         1:       return data_starts;
         default: return rd_count;
      endcase
   endfunction

   // Steps until the chosen counter moves; n = steps taken (== budget on timeout).
   task automatic wait_count(input int which, input int budget, output int n);
      int c0 = counter_of(which);
      n = 0;
      while (counter_of(which) == c0 && n < budget) begin
         tick();
         n++;
      end
   endtask

   task automatic wait_eof(input int budget);
      int n = 0;
      while (eof !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      check("eof_reached", 32'(eof), 1);
   endtask

   task automatic do_rewind();
      play   = 1'b0;
      rewind = 1'b1;
      tick();
      rewind = 1'b0;
      check("rewind_addr", 32'(bus.buf_addr), 0);
      check("rewind_eof", 32'(eof), 0);
      check("rewind_busy", 32'(busy), 0);
   endtask

   typedef struct {
      int          size;
      logic [31:0] img;      // byte i at img[8*i +: 8]
      int          lat;
      logic        exp_eof;
      int          exp_addr;
      int          exp_starts;
   } vec_t;

   vec_t vt [4];

   initial begin
      #800_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, r0;
      bit busy_seen;

      vt[0] = '{2, 32'h0000_3CA5, 1, 1'b1, 2, LB + 2};
      vt[1] = '{3, 32'h0055_FF00, 3, 1'b1, 3, LB + 3};
      vt[2] = '{1, 32'h0000_0080, 2, 1'b1, 1, LB + 1};
      vt[3] = '{0, 32'h0000_0000, 1, 1'b0, 0, 0};
      for (int i = 0; i < 16; i++) mem[i] = 8'h00;

      // reset state
      repeat (3) tick();
      check("rst_buf_rd", 32'(bus.buf_rd), 0);
      check("rst_buf_addr", 32'(bus.buf_addr), 0);
      check("rst_gen_start", 32'(bus.gen_start), 0);
      check("rst_gen_din", 32'(bus.gen_din), 0);
      check("rst_gen_extend", 32'(bus.gen_extend), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_eof", 32'(eof), 0);
      reset = 1'b0;
      tick();

      // table-driven playback
      for (int v = 0; v < 4; v++) begin
         for (int i = 0; i < vt[v].size; i++) mem[i] = vt[v].img[8*i +: 8];
         img_size = AW'(vt[v].size);
         ack_lat  = vt[v].lat;
         r0       = start_count;
         if (vt[v].size != 0) begin
            push_leader();
            for (int i = 0; i < vt[v].size; i++) push_data(vt[v].img[8*i +: 8]);
         end
         play  = 1'b1;
         motor = 1'b1;
         if (vt[v].size == 0) begin
            busy_seen = 1'b0;
            repeat (40) begin
               tick();
               if (busy) busy_seen = 1'b1;
            end
            check("empty_never_busy", 32'(busy_seen), 0);
         end else begin
            wait_count(0, 200, n);
            check("gap_to_first_start", n, START_LAT);
            wait_eof(2000);
         end
         check("vec_eof", 32'(eof), 32'(vt[v].exp_eof));
         check("vec_end_addr", 32'(bus.buf_addr), vt[v].exp_addr);
         check("vec_start_count", start_count - r0, vt[v].exp_starts);
         check("vec_sb_empty", sb_q.size(), 0);
         do_rewind();
      end

      // motor drop during the first data byte of a 4-byte image
      mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
      img_size = 4;
      ack_lat  = 2;
      push_leader(); push_data(8'h11);
      push_leader(); push_data(8'h22); push_data(8'h33); push_data(8'h44);
      play  = 1'b1;
      motor = 1'b1;
      wait_count(1, 300, n);
      motor = 1'b0;
      r0 = rd_count;
      repeat (50) tick();
      check("pause_no_buf_rd", rd_count - r0, 0);
      check("pause_addr", 32'(bus.buf_addr), 1);
      check("pause_busy", 32'(busy), 1);
      check("pause_sb_left", sb_q.size(), 5);
      motor = 1'b1;
      wait_count(0, 200, n);
      check("resume_gap_to_start", n, START_LAT);
      wait_eof(2000);
      check("motor_end_addr", 32'(bus.buf_addr), 4);
      check("motor_sb_empty", sb_q.size(), 0);
      do_rewind();

      // stale done held high after start
      mem[0] = 8'h5A; mem[1] = 8'hC3;
      img_size   = 2;
      ack_lat    = 3;
      stale_mode = 1'b1;
      push_leader(); push_data(8'h5A); push_data(8'hC3);
      play = 1'b1;
      wait_count(1, 300, n);
      wait_count(2, 100, n);
      check("stale_start_to_rd", n, GEN_LAT + 1);
      wait_count(0, 100, n);
      check("rd_to_start", n, ack_lat + 1);
      wait_eof(2000);
      check("stale_end_addr", 32'(bus.buf_addr), 2);
      check("stale_sb_empty", sb_q.size(), 0);
      stale_mode = 1'b0;
      do_rewind();

      // reset in WAIT_DONE, restart, then rewind while busy
      mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56;
      img_size = 3;
      ack_lat  = 1;
      push_leader(); push_data(8'h12); push_data(8'h34); push_data(8'h56);
      play = 1'b1;
      wait_count(1, 300, n);
      repeat (4) tick();
      reset = 1'b1;
      tick();
      check("midrst_busy", 32'(busy), 0);
      check("midrst_eof", 32'(eof), 0);
      check("midrst_addr", 32'(bus.buf_addr), 0);
      check("midrst_buf_rd", 32'(bus.buf_rd), 0);
      check("midrst_gen_start", 32'(bus.gen_start), 0);
      check("midrst_gen_din", 32'(bus.gen_din), 0);
      check("midrst_gen_extend", 32'(bus.gen_extend), 0);
      sb_q.delete();
      reset = 1'b0;
      push_leader(); push_data(8'h12); push_data(8'h34); push_data(8'h56);
      wait_count(0, 200, n);
      check("midrst_gap_to_start", n, START_LAT);
      wait_count(1, 300, n);
      wait_count(1, 300, n);
      rewind = 1'b1;
      tick();
      rewind = 1'b0;
      check("rewind_busy_ignored_addr", 32'(bus.buf_addr), 1);
      check("rewind_busy_ignored_busy", 32'(busy), 1);
      wait_eof(2000);
      check("midrst_end_addr", 32'(bus.buf_addr), 3);
      check("midrst_sb_empty", sb_q.size(), 0);
      do_rewind();

`ifdef TAPE_HDR_DETECT_EN
      // header re-sync: four 0x55 data bytes then 0x7F
      for (int i = 0; i < 4; i++) mem[i] = 8'h55;
      mem[4] = 8'h7F; mem[5] = 8'h01;
      img_size = 6;
      push_leader();
      for (int i = 0; i < 4; i++) push_data(8'h55);
      push_leader(); push_data(8'h7F); push_data(8'h01);
      play = 1'b1;
      wait_eof(3000);
      check("hdr_end_addr", 32'(bus.buf_addr), 6);
      check("hdr_sb_empty", sb_q.size(), 0);
      do_rewind();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
